// File: rtl/ntr_cmd_capture.sv
// NTR cartridge bus command capture: synchronises the raw bus pins, assembles
// CMD_BYTES command bytes MSB-first and flags short frames.
// Optional build macro NTR_CMD_GLITCH_FILTER_EN adds a 2-sample agreement
// filter on ntr_clk/ntr_cs1 with matching data delay (+2 cycles latency).
module ntr_cmd_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CMD_BYTES   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ntr_clk,
  input  logic        ntr_cs1,
  input  logic [7:0]  ntr_data,
  output logic [63:0] cmd,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic [3:0]  byte_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0]  LAST_CNT = 4'(CMD_BYTES);
  localparam int unsigned PAD_BITS = 8 * (8 - CMD_BYTES);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [7:0]             data_sync [SYNC_STAGES];

  logic       s_clk;
  logic       s_cs;
  logic [7:0] s_data;
  logic       s_clk_d;
  logic       rise;

  state_t      state, state_nxt;
  logic [63:0] sr, sr_nxt;
  logic [63:0] cmd_nxt;
  logic [3:0]  cnt_nxt;
  logic        valid_nxt;
  logic        err_pend, err_pend_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '0;
      cs_sync  <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      clk_sync     <= {clk_sync[SYNC_STAGES-2:0], ntr_clk};
      cs_sync      <= {cs_sync[SYNC_STAGES-2:0], ntr_cs1};
      data_sync[0] <= ntr_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

`ifdef NTR_CMD_GLITCH_FILTER_EN
  logic       clk_prev, clk_flt;
  logic       cs_prev, cs_flt;
  logic [7:0] data_d1, data_d2;

  // Filtered level follows only after two consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_prev <= 1'b0;
      clk_flt  <= 1'b0;
      cs_prev  <= 1'b0;
      cs_flt   <= 1'b0;
      data_d1  <= '0;
      data_d2  <= '0;
    end else begin
      clk_prev <= clk_sync[SYNC_STAGES-1];
      cs_prev  <= cs_sync[SYNC_STAGES-1];
      if (clk_sync[SYNC_STAGES-1] == clk_prev && clk_sync[SYNC_STAGES-1] != clk_flt)
        clk_flt <= clk_sync[SYNC_STAGES-1];
      if (cs_sync[SYNC_STAGES-1] == cs_prev && cs_sync[SYNC_STAGES-1] != cs_flt)
        cs_flt <= cs_sync[SYNC_STAGES-1];
      data_d1 <= data_sync[SYNC_STAGES-1];
      data_d2 <= data_d1;
    end
  end

  assign s_clk  = clk_flt;
  assign s_cs   = cs_flt;
  assign s_data = data_d2;
`else
  assign s_clk  = clk_sync[SYNC_STAGES-1];
  assign s_cs   = cs_sync[SYNC_STAGES-1];
  assign s_data = data_sync[SYNC_STAGES-1];
`endif

  assign rise = s_clk & ~s_clk_d;
  assign busy = (state == SHIFT) || (state == DONE);

  always_comb begin
    state_nxt    = state;
    sr_nxt       = sr;
    cmd_nxt      = cmd;
    cnt_nxt      = byte_cnt;
    valid_nxt    = 1'b0;
    err_pend_nxt = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (s_cs) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sr_nxt    = '0;
        end
      end
      IDLE: begin
        if (!s_cs) state_nxt = SHIFT;
      end
      SHIFT: begin
        // Completion is evaluated the cycle after the last byte lands; a cs1
        // rise coinciding with a clock edge discards that byte.
        if (byte_cnt == LAST_CNT) begin
          cmd_nxt   = sr << PAD_BITS;
          valid_nxt = 1'b1;
          state_nxt = DONE;
        end else if (s_cs) begin
          err_pend_nxt = (byte_cnt != '0);
          state_nxt    = IDLE;
          cnt_nxt      = '0;
          sr_nxt       = '0;
        end else if (rise) begin
          sr_nxt  = {sr[55:0], s_data};
          cnt_nxt = byte_cnt + 4'd1;
        end
      end
      DONE: begin
        if (s_cs) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sr_nxt    = '0;
        end
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_HIGH;
      s_clk_d   <= 1'b0;
      sr        <= '0;
      cmd       <= '0;
      byte_cnt  <= '0;
      cmd_valid <= 1'b0;
      err_pend  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_clk_d   <= s_clk;
      sr        <= sr_nxt;
      cmd       <= cmd_nxt;
      byte_cnt  <= cnt_nxt;
      cmd_valid <= valid_nxt;
      err_pend  <= err_pend_nxt;
      frame_err <= err_pend;
    end
  end

endmodule

// File: tb/tb_ntr_cmd_capture.sv
// Directed bench for ntr_cmd_capture: table of frames plus hand sequences for
// latency, simultaneous cs1/clock rise, reset mid-frame and glitch rejection.
module tb_ntr_cmd_capture;

  localparam int PH = 8;
`ifdef NTR_CMD_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic        clk;
  logic        rst;
  logic        ntr_clk;
  logic        ntr_cs1;
  logic [7:0]  ntr_data;
  logic [63:0] cmd;
  logic        cmd_valid;
  logic        frame_err;
  logic [3:0]  byte_cnt;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;

  ntr_cmd_capture #(.SYNC_STAGES(2), .CMD_BYTES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ntr_clk   (ntr_clk),
    .ntr_cs1   (ntr_cs1),
    .ntr_data  (ntr_data),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .byte_cnt  (byte_cnt),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (cmd_valid) n_valid++;
    if (frame_err) n_err++;
    if (cmd_valid && frame_err) n_both++;
  end

  typedef struct {
    logic [63:0] data;
    int          nbytes;
    int          extra;
    logic [63:0] exp_cmd;
    int          exp_cnt;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ntr_data = b;
    ntr_clk  = 1'b0;
    cyc(PH);
    ntr_clk  = 1'b1;
    cyc(PH);
  endtask

  task automatic send_bytes(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) send_byte(d[63-8*i -: 8]);
  endtask

  initial begin
    int v0, e0;
    logic [63:0] last_cmd;

    vecs[0] = '{64'hFF00_0000_0000_0001, 8, 0, 64'hFF00_0000_0000_0001, 8, 1, 0};
    vecs[1] = '{64'hAABB_CC00_0000_0000, 3, 0, 64'hFF00_0000_0000_0001, 3, 0, 1};
    vecs[2] = '{64'h0,                   0, 0, 64'hFF00_0000_0000_0001, 0, 0, 0};
    vecs[3] = '{64'h0102_0304_0506_0708, 8, 2, 64'h0102_0304_0506_0708, 8, 1, 0};
    vecs[4] = '{64'hDEAD_BEEF_CAFE_F00D, 7, 0, 64'h0102_0304_0506_0708, 7, 0, 1};
    vecs[5] = '{64'hA5A5_A5A5_A5A5_A5A5, 8, 0, 64'hA5A5_A5A5_A5A5_A5A5, 8, 1, 0};

    rst = 1'b1; ntr_cs1 = 1'b1; ntr_clk = 1'b0; ntr_data = 8'h00;
    cyc(2);
    chk("rst_cmd", cmd, 64'h0);
    chk("rst_valid", {63'h0, cmd_valid}, 64'h0);
    chk("rst_err", {63'h0, frame_err}, 64'h0);
    chk("rst_cnt", {60'h0, byte_cnt}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    rst = 1'b0;
    cyc(PH);

    // Clock edges with cs1 high
    v0 = n_valid; e0 = n_err;
    send_bytes(64'h1234_5678_0000_0000, 4);
    ntr_clk = 1'b0;
    cyc(PH);
    chk("idle_cnt", {60'h0, byte_cnt}, 64'h0);
    chk("idle_busy", {63'h0, busy}, 64'h0);
    chk("idle_pulses", 64'(n_valid - v0 + n_err - e0), 64'h0);

    for (int k = 0; k < 6; k++) begin
      v0 = n_valid; e0 = n_err;
      ntr_cs1 = 1'b0;
      cyc(PH);
      send_bytes(vecs[k].data, vecs[k].nbytes);
      for (int x = 0; x < vecs[k].extra; x++) send_byte(8'h5A);
      ntr_clk = 1'b0;
      cyc(PH);
      chk($sformatf("v%0d_cnt", k), {60'h0, byte_cnt}, 64'(vecs[k].exp_cnt));
      chk($sformatf("v%0d_busy", k), {63'h0, busy}, 64'h1);
      ntr_cs1 = 1'b1;
      cyc(PH);
      chk($sformatf("v%0d_cmd", k), cmd, vecs[k].exp_cmd);
      chk($sformatf("v%0d_valid", k), 64'(n_valid - v0), 64'(vecs[k].exp_valid));
      chk($sformatf("v%0d_err", k), 64'(n_err - e0), 64'(vecs[k].exp_err));
      chk($sformatf("v%0d_idle_cnt", k), {60'h0, byte_cnt}, 64'h0);
      chk($sformatf("v%0d_idle_busy", k), {63'h0, busy}, 64'h0);
    end

    // cmd_valid latency from the first clk edge seeing the final ntr_clk rise
    ntr_cs1 = 1'b0;
    cyc(PH);
    send_bytes(64'h0F1E_2D3C_4B5A_6978, 7);
    ntr_data = 8'h78; ntr_clk = 1'b0;
    cyc(PH);
    ntr_clk = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("lat_valid_early", {63'h0, cmd_valid}, 64'h0);
    @(posedge clk);
    #1 chk("lat_valid", {63'h0, cmd_valid}, 64'h1);
    chk("lat_cmd", cmd, 64'h0F1E_2D3C_4B5A_6978);
    @(posedge clk);
    #1 chk("lat_valid_pulse", {63'h0, cmd_valid}, 64'h0);
    cyc(PH);
    ntr_clk = 1'b0;
    cyc(PH);
    ntr_cs1 = 1'b1;
    cyc(PH);

    // cs1 rise coincides with the 8th ntr_clk rise
    v0 = n_valid; e0 = n_err;
    ntr_cs1 = 1'b0;
    cyc(PH);
    send_bytes(64'h1111_1111_1111_1100, 7);
    ntr_data = 8'h99; ntr_clk = 1'b0;
    cyc(PH);
    ntr_clk = 1'b1; ntr_cs1 = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("sim_err_early", {63'h0, frame_err}, 64'h0);
    @(posedge clk);
    #1 chk("sim_err", {63'h0, frame_err}, 64'h1);
    @(posedge clk);
    #1 chk("sim_err_pulse", {63'h0, frame_err}, 64'h0);
    ntr_clk = 1'b0;
    cyc(PH);
    chk("sim_no_valid", 64'(n_valid - v0), 64'h0);
    chk("sim_err_cnt", 64'(n_err - e0), 64'h1);
    chk("sim_cmd_kept", cmd, 64'h0F1E_2D3C_4B5A_6978);

    // Reset mid-frame, then released with cs1 still low
    v0 = n_valid; e0 = n_err;
    ntr_cs1 = 1'b0;
    cyc(PH);
    send_bytes(64'h2222_2222_0000_0000, 4);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd", cmd, 64'h0);
    chk("mid_rst_cnt", {60'h0, byte_cnt}, 64'h0);
    chk("mid_rst_busy", {63'h0, busy}, 64'h0);
    cyc(2);
    rst = 1'b0;
    send_bytes(64'h3333_3333_3333_3333, 8);
    ntr_clk = 1'b0;
    cyc(PH);
    chk("wait_high_cnt", {60'h0, byte_cnt}, 64'h0);
    chk("wait_high_busy", {63'h0, busy}, 64'h0);
    ntr_cs1 = 1'b1;
    cyc(PH);
    chk("mid_rst_pulses", 64'(n_valid - v0 + n_err - e0), 64'h0);
    chk("mid_rst_cmd_hold", cmd, 64'h0);
    v0 = n_valid;
    ntr_cs1 = 1'b0;
    cyc(PH);
    send_bytes(64'h1122_3344_5566_7788, 8);
    ntr_clk = 1'b0;
    cyc(PH);
    ntr_cs1 = 1'b1;
    cyc(PH);
    chk("post_rst_cmd", cmd, 64'h1122_3344_5566_7788);
    chk("post_rst_valid", 64'(n_valid - v0), 64'h1);

`ifdef NTR_CMD_GLITCH_FILTER_EN
    v0 = n_valid; e0 = n_err;
    ntr_cs1 = 1'b0;
    cyc(PH);
    send_bytes(64'hC0C1_C200_0000_0000, 3);
    ntr_clk = 1'b0;
    cyc(PH);
    ntr_clk = 1'b1;
    cyc(1);
    ntr_clk = 1'b0;
    cyc(PH);
    chk("glitch_cnt", {60'h0, byte_cnt}, 64'h3);
    send_bytes(64'hC3C4_C5C6_C700_0000, 5);
    ntr_clk = 1'b0;
    cyc(PH);
    ntr_cs1 = 1'b1;
    cyc(PH);
    chk("glitch_cmd", cmd, 64'hC0C1_C2C3_C4C5_C6C7);
    chk("glitch_valid", 64'(n_valid - v0 + n_err - e0), 64'h1);
`endif

    chk("valid_err_overlap", 64'(n_both), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
